// File: rtl/pfd_pkg.sv
// Shared types, default constants and arithmetic helpers for the PFD lock detector.
package pfd_pkg;

    // Lock detector FSM states.
    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        ACQUIRING = 2'd1,
        LOCKED    = 2'd2,
        LOSING    = 2'd3
    } pfd_state_e;

    // Default measurement window length and quiet-window threshold.
    localparam int WIN_LEN_DEF    = 64;
    localparam int ERR_THRESH_DEF = 4;

    // Signed add that clamps to the range of a w-bit two's complement value
    // (w <= 31). Operands are expected to already lie inside that range.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 w
    );
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = 33'(a) + 33'(b);
        hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (w - 1));
        if (sum > hi) begin
            sat_add = 32'(hi);
        end else if (sum < lo) begin
            sat_add = 32'(lo);
        end else begin
            sat_add = 32'(sum);
        end
    endfunction

endpackage

// File: rtl/pfd_sync2.sv
// Two-flop synchroniser bringing an asynchronous PFD pulse into the clk domain.
module pfd_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    // Shift the asynchronous input through two flops; the first may go metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/pfd_lock_detect.sv
// PFD back end: synchronises UP/DOWN pulses, integrates net phase error into a
// saturating accumulator, and runs a windowed lock detector with hysteresis.
module pfd_lock_detect
    import pfd_pkg::*;
#(
    parameter int WIN_LEN    = WIN_LEN_DEF,
    parameter int ERR_THRESH = ERR_THRESH_DEF,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int ACC_W      = 12
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                qa,
    input  logic                                qb,
    input  logic                                enable,
    output logic                                up_sync,
    output logic                                dn_sync,
    output logic signed [ACC_W-1:0]             phase_acc,
    output logic [$clog2(WIN_LEN+1)-1:0]        err_count,
    output logic                                win_done,
    output logic                                locked
);

    localparam int WIN_W = $clog2(WIN_LEN);
    localparam int ERR_W = $clog2(WIN_LEN + 1);
    localparam int Q_W   = $clog2(LOCK_CNT + 1);
    localparam int N_W   = $clog2(UNLOCK_CNT + 1);

    logic                    up_sync_s;
    logic                    dn_sync_s;
    logic                    err_cyc_s;
    logic                    win_end_s;
    logic                    quiet_s;
    logic [ERR_W-1:0]        err_total_s;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic [WIN_W-1:0]        win_cnt_q;
    logic [WIN_W-1:0]        win_cnt_d;
    logic [ERR_W-1:0]        err_cnt_q;
    logic [ERR_W-1:0]        err_cnt_d;

    pfd_state_e              state_q;
    logic [Q_W-1:0]          q_cnt_q;
    logic [N_W-1:0]          n_cnt_q;
    logic                    locked_q;
    logic                    win_done_q;
    logic [ERR_W-1:0]        err_count_q;

    pfd_sync2 u_sync_up (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (qa),
        .q_o   (up_sync_s)
    );

    pfd_sync2 u_sync_dn (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (qb),
        .q_o   (dn_sync_s)
    );

    // An error cycle is exactly one of UP/DOWN active; overlap is the PFD reset pulse.
    assign err_cyc_s   = up_sync_s ^ dn_sync_s;
    assign win_end_s   = enable && (win_cnt_q == WIN_W'(WIN_LEN - 1));
    assign err_total_s = err_cnt_q + ERR_W'(err_cyc_s);
    assign quiet_s     = (32'(err_total_s) <= 32'(ERR_THRESH));

    // Accumulator next value: +1 for UP-only, -1 for DOWN-only, clamped, held when disabled.
    always_comb begin
        acc_d = acc_q;
        if (enable && up_sync_s && !dn_sync_s) begin
            acc_d = ACC_W'(sat_add(32'(acc_q), 32'sd1, ACC_W));
        end else if (enable && dn_sync_s && !up_sync_s) begin
            acc_d = ACC_W'(sat_add(32'(acc_q), -32'sd1, ACC_W));
        end else begin
            acc_d = acc_q;
        end
    end

    // Window and error counters: restart on window end, clear while disabled.
    always_comb begin
        win_cnt_d = win_cnt_q;
        err_cnt_d = err_cnt_q;
        if (!enable) begin
            win_cnt_d = '0;
            err_cnt_d = '0;
        end else if (win_end_s) begin
            win_cnt_d = '0;
            err_cnt_d = '0;
        end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            err_cnt_d = err_total_s;
        end
    end

    // Datapath registers for the accumulator and window counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            win_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            win_cnt_q <= win_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Lock FSM with registered window result and lock flag, evaluated at window end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNLOCKED;
            q_cnt_q     <= '0;
            n_cnt_q     <= '0;
            locked_q    <= 1'b0;
            win_done_q  <= 1'b0;
            err_count_q <= '0;
        end else if (!enable) begin
            state_q     <= UNLOCKED;
            q_cnt_q     <= '0;
            n_cnt_q     <= '0;
            locked_q    <= 1'b0;
            win_done_q  <= 1'b0;
        end else if (win_end_s) begin
            win_done_q  <= 1'b1;
            err_count_q <= err_total_s;
            case (state_q)
                UNLOCKED: begin
                    n_cnt_q <= '0;
                    if (quiet_s) begin
                        if (LOCK_CNT == 1) begin
                            state_q  <= LOCKED;
                            q_cnt_q  <= '0;
                            locked_q <= 1'b1;
                        end else begin
                            state_q  <= ACQUIRING;
                            q_cnt_q  <= Q_W'(1);
                            locked_q <= 1'b0;
                        end
                    end else begin
                        state_q  <= UNLOCKED;
                        q_cnt_q  <= '0;
                        locked_q <= 1'b0;
                    end
                end
                ACQUIRING: begin
                    n_cnt_q <= '0;
                    if (quiet_s) begin
                        if (32'(q_cnt_q) + 32'd1 >= 32'(LOCK_CNT)) begin
                            state_q  <= LOCKED;
                            q_cnt_q  <= '0;
                            locked_q <= 1'b1;
                        end else begin
                            state_q  <= ACQUIRING;
                            q_cnt_q  <= q_cnt_q + Q_W'(1);
                            locked_q <= 1'b0;
                        end
                    end else begin
                        state_q  <= UNLOCKED;
                        q_cnt_q  <= '0;
                        locked_q <= 1'b0;
                    end
                end
                LOCKED: begin
                    q_cnt_q <= '0;
                    if (!quiet_s) begin
                        if (UNLOCK_CNT == 1) begin
                            state_q  <= UNLOCKED;
                            n_cnt_q  <= '0;
                            locked_q <= 1'b0;
                        end else begin
                            state_q  <= LOSING;
                            n_cnt_q  <= N_W'(1);
                            locked_q <= 1'b1;
                        end
                    end else begin
                        state_q  <= LOCKED;
                        n_cnt_q  <= '0;
                        locked_q <= 1'b1;
                    end
                end
                LOSING: begin
                    q_cnt_q <= '0;
                    if (!quiet_s) begin
                        if (32'(n_cnt_q) + 32'd1 >= 32'(UNLOCK_CNT)) begin
                            state_q  <= UNLOCKED;
                            n_cnt_q  <= '0;
                            locked_q <= 1'b0;
                        end else begin
                            state_q  <= LOSING;
                            n_cnt_q  <= n_cnt_q + N_W'(1);
                            locked_q <= 1'b1;
                        end
                    end else begin
                        state_q  <= LOCKED;
                        n_cnt_q  <= '0;
                        locked_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= UNLOCKED;
                    q_cnt_q  <= '0;
                    n_cnt_q  <= '0;
                    locked_q <= 1'b0;
                end
            endcase
        end else begin
            win_done_q <= 1'b0;
        end
    end

    assign up_sync   = up_sync_s;
    assign dn_sync   = dn_sync_s;
    assign phase_acc = acc_q;
    assign err_count = err_count_q;
    assign win_done  = win_done_q;
    assign locked    = locked_q;

endmodule
